// File: rtl/rf_pkg.sv
// Shared register-file types: word/address widths and the writeback requester ids.
package rf_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = $clog2(NREG);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Requester ids double as bit positions in the arbiter req/grant vectors.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. A lone request is granted; on a tie the
// requester that did not win last time is granted. The pointer only moves
// when the owner signals advance (a completed transfer).
module rr_arbiter2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    req_e last;

    // Grant decode: ALU wins alone or on a tie when MEM won last.
    always_comb begin
        grant = '0;
        if (req[REQ_ALU] && (!req[REQ_MEM] || last == REQ_MEM))
            grant[REQ_ALU] = 1'b1;
        else if (req[REQ_MEM])
            grant[REQ_MEM] = 1'b1;
    end

    // Pointer: reset to "ALU went last" so the first tie goes to MEM.
    always_ff @(posedge clk) begin
        if (rst)
            last <= REQ_ALU;
        else if (advance)
            last <= grant[REQ_MEM] ? REQ_MEM : REQ_ALU;
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Shares the register-file write port between the ALU and load pipes,
// registers the granted write, and tracks in-flight destinations so decode
// can stall on operands that still have a pending write.
module rf_writeback_arbiter #(
    parameter  int XLEN = rf_pkg::XLEN,
    parameter  int NREG = rf_pkg::NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            stall_rs1,
    output logic            stall_rs2,
    output logic            wb_en,
    output logic [AW-1:0]   wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            idle
);

    import rf_pkg::*;

    logic [1:0]      req;
    logic [1:0]      grant;
    logic            xfer;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_set;
    logic [NREG-1:0] busy_clr;

    assign req = {mem_valid, alu_valid};

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (xfer),
        .grant   (grant)
    );

    // Ready is the grant itself, so a transfer is simply any grant.
    assign alu_ready = grant[REQ_ALU];
    assign mem_ready = grant[REQ_MEM];
    assign xfer      = |grant;

    // Select the winning requester's destination and data.
    always_comb begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
        if (grant[REQ_MEM]) begin
            sel_rd   = mem_rd;
            sel_data = mem_data;
        end
    end

    // Output stage: load on every transfer, pulse wb_en unless the target is x0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else if (xfer) begin
            wb_en   <= (sel_rd != '0);
            wb_rd   <= sel_rd;
            wb_data <= sel_data;
        end else begin
            wb_en   <= 1'b0;
        end
    end

    // Scoreboard masks: x0 is never marked; the write in flight clears its target.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (sb_set && sb_rd != '0)
            busy_set[sb_rd] = 1'b1;
        if (wb_en)
            busy_clr[wb_rd] = 1'b1;
    end

    // Scoreboard register: set is applied after clear so a new producer wins.
    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= (busy & ~busy_clr) | busy_set;
    end

    assign stall_rs1 = (rs1 != '0) && busy[rs1];
    assign stall_rs2 = (rs2 != '0) && busy[rs2];
    assign idle      = (busy == '0) && !wb_en;

endmodule
